// File: rtl/cpen391_pio_pkg.sv
// Shared register map and edge-select encodings for the CPEN391 input PIO slave.
// Macro INPUT_PIO_DEBOUNCE_EN selects the debounced build.
package cpen391_pio_pkg;

    localparam int unsigned BUS_W = 32;
    localparam int unsigned ADDR_W = 2;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_SEL = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 2'd3;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

`ifdef INPUT_PIO_DEBOUNCE_EN
    localparam bit DEBOUNCE_EN = 1'b1;
`else
    localparam bit DEBOUNCE_EN = 1'b0;
`endif

endpackage

// File: rtl/cpen391_input_pio_debounce.sv
// One input bit: multi-flop synchroniser followed by an optional stability filter.
// Macro INPUT_PIO_DEBOUNCE_EN enables the per-bit debounce counter.
module cpen391_input_pio_debounce #(
    parameter int unsigned SYNC_STAGES = 2
`ifdef INPUT_PIO_DEBOUNCE_EN
    , parameter int unsigned DEBOUNCE_CYCLES = 50000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic stable_o
);

    localparam int unsigned LAST = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   stable_q, stable_d;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], in_i};
    assign stable_o = stable_q;

`ifdef INPUT_PIO_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept the synchronised value only after it has differed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[LAST] != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_q[LAST];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    assign stable_d = sync_q[LAST];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
        end
    end
`endif

endmodule

// File: rtl/cpen391_input_pio.sv
// Avalon-MM input PIO: synchronised/debounced inputs, selectable edge capture, maskable irq.
// Macro INPUT_PIO_DEBOUNCE_EN enables per-bit debounce filtering.
module cpen391_input_pio
    import cpen391_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter logic [31:0] IRQ_RESET_MASK  = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    // Edges stay disarmed until inputs held through reset have propagated to stable.
    localparam int unsigned FILTER_LAT = DEBOUNCE_EN ? DEBOUNCE_CYCLES : 1;
    localparam int unsigned ARM_CYCLES = SYNC_STAGES + FILTER_LAT + 2;
    localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] edge_det;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [BUS_W-1:0] readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             armed;
    logic             wr;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        cpen391_input_pio_debounce #(
            .SYNC_STAGES(SYNC_STAGES)
`ifdef INPUT_PIO_DEBOUNCE_EN
            , .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`endif
        ) u_debounce (
            .clk     (clk),
            .reset   (reset),
            .in_i    (in_port[i]),
            .stable_o(stable[i])
        );
    end

    assign armed = (arm_cnt_q == ARM_W'(ARM_CYCLES));
    assign wr    = chipselect && !write_n;

    always_comb begin
        arm_cnt_d  = armed ? arm_cnt_q : arm_cnt_q + ARM_W'(1);
        edge_det   = '0;
        edge_sel_d = edge_sel_q;
        irq_mask_d = irq_mask_q;
        edge_cap_d = edge_cap_q;
        readdata_d = '0;

        for (int i = 0; i < WIDTH; i++) begin
            if (edge_sel_q[i] == EDGE_RISING) begin
                edge_det[i] = armed && !prev_q[i] && stable[i];
            end else begin
                edge_det[i] = armed && prev_q[i] && !stable[i];
            end
        end

        if (wr && (address == ADDR_EDGE_SEL)) edge_sel_d = writedata[WIDTH-1:0];
        if (wr && (address == ADDR_IRQ_MASK)) irq_mask_d = writedata[WIDTH-1:0];
        if (wr && (address == ADDR_EDGE_CAP)) edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
        // A new edge overrides a same-cycle clear.
        edge_cap_d = edge_cap_d | edge_det;

        irq_d = |(edge_cap_q & irq_mask_q);

        case (address)
            ADDR_DATA:     readdata_d = BUS_W'(stable);
            ADDR_EDGE_SEL: readdata_d = BUS_W'(edge_sel_q);
            ADDR_IRQ_MASK: readdata_d = BUS_W'(irq_mask_q);
            ADDR_EDGE_CAP: readdata_d = BUS_W'(edge_cap_q);
            default:       readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt_q  <= '0;
            prev_q     <= '0;
            edge_sel_q <= '0;
            irq_mask_q <= IRQ_RESET_MASK[WIDTH-1:0];
            edge_cap_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            arm_cnt_q  <= arm_cnt_d;
            prev_q     <= stable;
            edge_sel_q <= edge_sel_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
